// File: rtl/serial_bit_source_if.sv
// serial_bit_source_if
//   Groups the word-load handshake and serial output stream of
//   serial_bit_source into one bundle.
//   master : word producer / bit consumer (drives data_in, load_valid, shift_en)
//   slave  : the serializer (drives load_ready, ser_out, ser_valid,
//            word_done, busy)
interface serial_bit_source_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in, load_valid, shift_en,
    input  load_ready, ser_out, ser_valid, word_done, busy
  );

  modport slave (
    input  data_in, load_valid, shift_en,
    output load_ready, ser_out, ser_valid, word_done, busy
  );
endinterface

// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Parallel-to-serial converter with a one-entry holding register so that
//   consecutive words stream out with no gap cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of serial_bit_source_if
//     data_in/load_valid/load_ready : word load handshake
//     shift_en                      : downstream consumes one bit per cycle
//     ser_out/ser_valid             : current serial bit and its qualifier
//     word_done                     : pulse while the last bit is consumed
//     busy                          : shift or holding register occupied
module serial_bit_source #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                reset,
  serial_bit_source_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic             full_q,  full_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shreg_adv;

  assign accept   = bus.load_valid && !full_q;
  assign last_bit = (state_q == SHIFT) && bus.shift_en && (cnt_q == '0);

  always_comb begin
    shreg_adv = '0;
    if (MSB_FIRST) begin
      shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    hold_d  = hold_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.data_in;
          cnt_d   = LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Word boundary: the held word has priority; a same-edge load only
          // reaches here when holding is empty and bypasses it entirely.
          if (full_q) begin
            shreg_d = hold_q;
            full_d  = 1'b0;
            cnt_d   = LAST;
          end else if (accept) begin
            shreg_d = bus.data_in;
            cnt_d   = LAST;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          if (bus.shift_en) begin
            shreg_d = shreg_adv;
            cnt_d   = cnt_q - CW'(1);
          end
          if (accept) begin
            hold_d = bus.data_in;
            full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  // Serial outputs decode registered state only; data_in never reaches them.
  assign bus.ser_valid  = (state_q == SHIFT);
  assign bus.ser_out    = (state_q == SHIFT) &&
                          (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign bus.word_done  = last_bit;
  assign bus.busy       = (state_q == SHIFT) || full_q;
  assign bus.load_ready = !full_q;

endmodule

// File: tb/tb_serial_bit_source.sv
module tb_serial_bit_source;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       load_valid = 1'b0;
  logic       shift_en = 1'b0;

  int total = 0;
  int bad = 0;

  // Reference model: queue of words not yet fully consumed; pos is the
  // index (in transmission order) of the bit currently presented.
  logic [7:0] wq[$];
  int         pos = 0;

  logic [15:0] cap_m = '0;
  logic [15:0] cap_l = '0;
  int          wd_cnt = 0;

  always #5 clk = ~clk;

  serial_bit_source_if #(.WIDTH(8)) ifm ();
  serial_bit_source_if #(.WIDTH(8)) ifl ();

  assign ifm.data_in    = data_in;
  assign ifm.load_valid = load_valid;
  assign ifm.shift_en   = shift_en;
  assign ifl.data_in    = data_in;
  assign ifl.load_valid = load_valid;
  assign ifl.shift_en   = shift_en;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm.slave)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (ifl.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic check_now();
    logic       v, rdy, wd, eo_m, eo_l;
    logic [7:0] w;
    v    = (wq.size() > 0);
    rdy  = (wq.size() < 2);
    eo_m = 1'b0;
    eo_l = 1'b0;
    if (v) begin
      w    = wq[0];
      eo_m = w[7 - pos];
      eo_l = w[pos];
    end
    wd = v && shift_en && (pos == 7);
    chk("m_ser_valid",  ifm.ser_valid,  v);
    chk("m_ser_out",    ifm.ser_out,    eo_m);
    chk("m_word_done",  ifm.word_done,  wd);
    chk("m_busy",       ifm.busy,       v);
    chk("m_load_ready", ifm.load_ready, rdy);
    chk("l_ser_valid",  ifl.ser_valid,  v);
    chk("l_ser_out",    ifl.ser_out,    eo_l);
    chk("l_word_done",  ifl.word_done,  wd);
    chk("l_busy",       ifl.busy,       v);
    chk("l_load_ready", ifl.load_ready, rdy);
  endtask

  // One clock: check at negedge, advance model on posedge, return at posedge+1.
  task automatic step();
    logic v, rdy;
    @(negedge clk);
    check_now();
    v   = (wq.size() > 0);
    rdy = (wq.size() < 2);
    if (v && shift_en) begin
      cap_m = {cap_m[14:0], ifm.ser_out};
      cap_l = {cap_l[14:0], ifl.ser_out};
    end
    if (ifm.word_done) wd_cnt++;
    @(posedge clk);
    if (v && shift_en) begin
      pos++;
      if (pos == 8) begin
        void'(wq.pop_front());
        pos = 0;
      end
    end
    if (load_valid && rdy) wq.push_back(data_in);
    #1;
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    wq.delete();
    pos = 0;
    check_now();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] w);
    data_in    = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    do_reset();

    // Basic MSB-first word, loaded on the first edge after reset release.
    shift_en = 1'b1;
    cap_m = '0; wd_cnt = 0;
    load(8'hB0);
    repeat (8) step();
    chk("basic_bits", cap_m[7:0], 8'hB0);
    chk("basic_wd", wd_cnt, 1);
    repeat (2) step();

    // Back-to-back words, second loaded while first shifts.
    cap_m = '0; wd_cnt = 0;
    load(8'hB0);
    repeat (2) step();
    load(8'h0B);
    chk("b2b_ready_low", ifm.load_ready, 1'b0);
    repeat (14) step();
    chk("b2b_bits", cap_m, 16'hB00B);
    chk("b2b_wd", wd_cnt, 2);
    repeat (2) step();

    // Stall for three cycles after bit 2.
    cap_m = '0; wd_cnt = 0;
    load(8'hB0);
    repeat (2) step();
    shift_en = 1'b0;
    repeat (3) step();
    shift_en = 1'b1;
    repeat (6) step();
    chk("stall_bits", cap_m[7:0], 8'hB0);
    chk("stall_wd", wd_cnt, 1);
    repeat (2) step();

    // LSB-first instance presents 8'h0D as 1,0,1,1,0,0,0,0.
    cap_l = '0;
    load(8'h0D);
    repeat (8) step();
    chk("lsb_bits", cap_l[7:0], 8'hB0);
    repeat (2) step();

    // Same-edge load on the last-bit edge with holding empty.
    cap_m = '0;
    load(8'hB0);
    repeat (7) step();
    data_in = 8'h0B; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("same_edge_ready", ifm.load_ready, 1'b1);
    chk("same_edge_valid", ifm.ser_valid, 1'b1);
    repeat (8) step();
    chk("same_edge_bits", cap_m, 16'hB00B);
    repeat (2) step();

    // Reset mid-word with holding full.
    wd_cnt = 0;
    load(8'hFF);
    load(8'hA5);
    repeat (3) step();
    do_reset();
    chk("rst_ser_valid", ifm.ser_valid, 1'b0);
    chk("rst_busy", ifm.busy, 1'b0);
    chk("rst_ready", ifm.load_ready, 1'b1);
    repeat (10) step();
    chk("rst_no_wd", wd_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      data_in    = 8'($urandom);
      load_valid = ($urandom_range(0, 2) != 0);
      shift_en   = ($urandom_range(0, 3) != 0);
      if (i == 200) do_reset();
      step();
    end
    load_valid = 1'b0;
    shift_en   = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
